// File: rtl/gol_engine.sv
// Life-like cellular automaton array: WIDTH x HEIGHT grid, one generation per clock,
// runtime birth/survive rules, toroidal or dead-border edges, run/step/halt control.
module gol_engine #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 10,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [WIDTH*HEIGHT-1:0]   load_cells,
   input  logic [8:0]                birth_mask,
   input  logic [8:0]                survive_mask,
   input  logic                      wrap,
   input  logic                      run,
   input  logic                      step,
   input  logic                      halt_on_stable,
   output logic [WIDTH*HEIGHT-1:0]   cells,
   output logic [GEN_W-1:0]          gen_count,
   output logic                      running,
   output logic                      halted,
   output logic                      stable,
   output logic                      extinct
);

   localparam int N     = WIDTH * HEIGHT;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      cells_q, cells_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic              stable_q, stable_d;
   logic [N-1:0]      next_cells;
   logic [3:0]        nbr;
   logic              eq;
   logic              advance;

   // Out-of-grid positions read dead unless wrap folds them back onto the torus.
   function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c,
                                    input logic wr);
      int rr;
      int cc;
      if (!wr && (r < 0 || r >= HEIGHT || c < 0 || c >= WIDTH)) return 1'b0;
      rr = (r + HEIGHT) % HEIGHT;
      cc = (c + WIDTH) % WIDTH;
      return g[IDX_W'(rr * WIDTH + cc)];
   endfunction

   always_comb begin
      next_cells = '0;
      nbr        = '0;
      for (int unsigned r = 0; r < HEIGHT; r++) begin
         for (int unsigned c = 0; c < WIDTH; c++) begin
            nbr = '0;
            for (int unsigned dr = 0; dr < 3; dr++) begin
               for (int unsigned dc = 0; dc < 3; dc++) begin
                  if (!(dr == 1 && dc == 1))
                     nbr = nbr + 4'(cell_at(cells_q, int'(r) + int'(dr) - 1,
                                            int'(c) + int'(dc) - 1, wrap));
               end
            end
            next_cells[IDX_W'(r * WIDTH + c)] = cells_q[IDX_W'(r * WIDTH + c)] ?
                                                survive_mask[nbr] : birth_mask[nbr];
         end
      end
   end

   assign eq      = (next_cells == cells_q);
   assign advance = (state_q == RUN && run) || (state_q == IDLE && step);

   always_comb begin
      state_d  = state_q;
      cells_d  = cells_q;
      gen_d    = gen_q;
      stable_d = stable_q;
      if (load) begin
         cells_d  = load_cells;
         gen_d    = '0;
         stable_d = 1'b0;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (run)  state_d = RUN;
            RUN:     if (!run) state_d = IDLE;
            HALT:    if (!run) state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (advance) begin
            if (state_q == RUN && halt_on_stable && eq) begin
               state_d  = HALT;
               stable_d = 1'b1;
            end else begin
               cells_d  = next_cells;
               stable_d = eq;
               gen_d    = (gen_q == '1) ? gen_q : gen_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cells_q  <= '0;
         gen_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cells_q  <= cells_d;
         gen_q    <= gen_d;
         stable_q <= stable_d;
      end
   end

   assign cells     = cells_q;
   assign gen_count = gen_q;
   assign running   = (state_q == RUN);
   assign halted    = (state_q == HALT);
   assign stable    = stable_q;
   assign extinct   = (cells_q == '0);

endmodule

// File: tb/tb_gol_engine.sv
// Directed bench for gol_engine on a 5x5 grid: a 16-bit counter instance for the
// rule/edge/run/halt behaviour and a 4-bit counter instance for saturation.
module tb_gol_engine;

   localparam int W = 5;
   localparam int H = 5;
   localparam int N = W * H;

   localparam logic [8:0] CONWAY_B = 9'b000001000;
   localparam logic [8:0] CONWAY_S = 9'b000001100;
   localparam logic [8:0] HIGH_B   = 9'b001001000;

   logic          clk = 1'b0;
   logic          rst, load, wrap, run, step, hos;
   logic [N-1:0]  load_cells;
   logic [8:0]    birth_mask, survive_mask;

   logic [N-1:0]  cells_a, cells_b;
   logic [15:0]   gen_a;
   logic [3:0]    gen_b;
   logic          running_a, halted_a, stable_a, extinct_a;
   logic          running_b, halted_b, stable_b, extinct_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gol_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(16)) u_dut (
      .clk(clk), .rst(rst), .load(load), .load_cells(load_cells),
      .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap(wrap),
      .run(run), .step(step), .halt_on_stable(hos),
      .cells(cells_a), .gen_count(gen_a), .running(running_a), .halted(halted_a),
      .stable(stable_a), .extinct(extinct_a)
   );

   gol_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .load(load), .load_cells(load_cells),
      .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap(wrap),
      .run(run), .step(step), .halt_on_stable(hos),
      .cells(cells_b), .gen_count(gen_b), .running(running_b), .halted(halted_b),
      .stable(stable_b), .extinct(extinct_b)
   );

   typedef struct {
      string        name;
      logic [N-1:0] pattern;
      logic [8:0]   birth;
      logic [8:0]   survive;
      logic         wr;
      int           nsteps;
      logic [N-1:0] exp_cells;
      int           exp_gen;
      logic         exp_stable;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [N-1:0] b(input int i);
      logic [N-1:0] one = 1;
      return one << i;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] p);
      load_cells = p;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   logic [N-1:0] blinker_h, glider, block;

   initial begin
      rst = 1'b1; load = 1'b0; wrap = 1'b1; run = 1'b0; step = 1'b0; hos = 1'b0;
      load_cells = '0; birth_mask = CONWAY_B; survive_mask = CONWAY_S;
      blinker_h = b(11) | b(12) | b(13);
      glider    = b(1) | b(7) | b(10) | b(11) | b(12);
      block     = b(6) | b(7) | b(11) | b(12);

      vecs[0] = '{"blinker_1step", blinker_h, CONWAY_B, CONWAY_S, 1'b1, 1,
                  b(7) | b(12) | b(17), 1, 1'b0};
      vecs[1] = '{"blinker_2step", blinker_h, CONWAY_B, CONWAY_S, 1'b1, 2,
                  blinker_h, 2, 1'b0};
      vecs[2] = '{"edge_nowrap", b(0) | b(1) | b(2), CONWAY_B, CONWAY_S, 1'b0, 1,
                  b(1) | b(6), 1, 1'b0};
      vecs[3] = '{"edge_wrap", b(0) | b(1) | b(2), CONWAY_B, CONWAY_S, 1'b1, 1,
                  b(1) | b(6) | b(21), 1, 1'b0};
      vecs[4] = '{"highlife_six", b(6) | b(7) | b(8) | b(16) | b(17) | b(18),
                  HIGH_B, CONWAY_S, 1'b0, 1,
                  b(2) | b(7) | b(12) | b(17) | b(22), 1, 1'b0};

      tick(); tick();
      rst = 1'b0;
      check("rst_cells",   32'(cells_a),   32'd0);
      check("rst_gen",     32'(gen_a),     32'd0);
      check("rst_running", 32'(running_a), 32'd0);
      check("rst_halted",  32'(halted_a),  32'd0);
      check("rst_stable",  32'(stable_a),  32'd0);
      check("rst_extinct", 32'(extinct_a), 32'd1);

      for (int i = 0; i < 5; i++) begin
         birth_mask = vecs[i].birth;
         survive_mask = vecs[i].survive;
         wrap = vecs[i].wr;
         do_load(vecs[i].pattern);
         step = 1'b1;
         for (int s = 0; s < vecs[i].nsteps; s++) tick();
         step = 1'b0;
         check({vecs[i].name, "_cells"},  32'(cells_a),  32'(vecs[i].exp_cells));
         check({vecs[i].name, "_gen"},    32'(gen_a),    32'(vecs[i].exp_gen));
         check({vecs[i].name, "_stable"}, 32'(stable_a), 32'(vecs[i].exp_stable));
      end

      // Same six-neighbour pattern under Conway: centre must stay dead
      birth_mask = CONWAY_B; survive_mask = CONWAY_S; wrap = 1'b0;
      do_load(b(6) | b(7) | b(8) | b(16) | b(17) | b(18));
      step = 1'b1; tick(); step = 1'b0;
      check("conway_six_cells", 32'(cells_a), 32'(b(2) | b(7) | b(17) | b(22)));

      // Glider on a 5x5 torus returns home after 20 generations
      wrap = 1'b1;
      do_load(glider);
      run = 1'b1;
      tick();
      check("glider_enter_run", 32'(running_a), 32'd1);
      check("glider_gen_at_entry", 32'(gen_a), 32'd0);
      repeat (20) tick();
      check("glider_cells",   32'(cells_a),   32'(glider));
      check("glider_gen",     32'(gen_a),     32'd20);
      check("glider_running", 32'(running_a), 32'd1);
      run = 1'b0;
      tick();
      check("glider_exit_run", 32'(running_a), 32'd0);
      check("glider_hold_gen", 32'(gen_a),     32'd20);

      // Still life with halt_on_stable: halts without counting a generation
      hos = 1'b1;
      do_load(block);
      run = 1'b1;
      tick();
      check("block_running", 32'(running_a), 32'd1);
      tick();
      check("block_halted", 32'(halted_a), 32'd1);
      check("block_stable", 32'(stable_a), 32'd1);
      check("block_gen",    32'(gen_a),    32'd0);
      check("block_cells",  32'(cells_a),  32'(block));
      step = 1'b1; tick(); step = 1'b0;
      check("halt_step_gen",   32'(gen_a),    32'd0);
      check("halt_step_state", 32'(halted_a), 32'd1);
      run = 1'b0;
      tick();
      check("halt_exit_halted",  32'(halted_a),  32'd0);
      check("halt_exit_running", 32'(running_a), 32'd0);

      // Empty grid is a fixed point and halts as well
      do_load('0);
      check("empty_extinct", 32'(extinct_a), 32'd1);
      run = 1'b1;
      tick(); tick();
      check("empty_halted", 32'(halted_a), 32'd1);
      run = 1'b0;
      tick();
      hos = 1'b0;

      // 4-bit counter saturates, then reset mid-run clears everything
      do_load(blinker_h);
      run = 1'b1;
      repeat (21) tick();
      check("sat_gen4",  32'(gen_b), 32'd15);
      check("sat_gen16", 32'(gen_a), 32'd20);
      check("sat_cells4", 32'(cells_b), 32'(blinker_h));
      repeat (3) tick();
      check("sat_gen4_hold", 32'(gen_b), 32'd15);
      check("sat_cells4_odd", 32'(cells_b), 32'(b(7) | b(12) | b(17)));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_cells",   32'(cells_b),   32'd0);
      check("midrst_gen",     32'(gen_b),     32'd0);
      check("midrst_running", 32'(running_b), 32'd0);
      check("midrst_extinct", 32'(extinct_b), 32'd1);
      check("midrst_gen16",   32'(gen_a),     32'd0);
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
